// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, oversampling ratio, divider math.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud x16 tick generator: one-cycle tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_gen: DIV must be >= 1 (CLK_HZ too low for BAUD)");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX and RX FSMs sharing one baud x16 tick.
// Define UART_PARITY_EN to add a parity bit (sense set by PARITY_ODD) on both directions.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [1:0]           rx_err,
  output logic                 rx_overrun
);

  localparam int         DIV       = calc_div(CLK_HZ, BAUD);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_DBIT = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_SBIT = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
    $error("uart_core: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
    $error("uart_core: PARITY_ODD must be 0 or 1");
  end

  logic tick;
  uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .tick(tick));

  // ---------------- TX ----------------
  state_e                 tx_state_q, tx_state_d;
  logic [3:0]             tx_cnt_q, tx_cnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_q, tx_d, tx_end;
`ifdef UART_PARITY_EN
  logic                   tx_par_q, tx_par_d;
`endif

  assign tx_end   = tick && (tx_cnt_q == LAST_TICK);
  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == S_IDLE);
  assign tx_done  = (tx_state_q == S_STOP) && (tx_bit_q == LAST_SBIT) && tx_end;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tick) tx_cnt_d = tx_cnt_q + 4'd1;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      S_START: if (tx_end) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      S_DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_DBIT) begin
          tx_bit_d = '0;
`ifdef UART_PARITY_EN
          tx_state_d = S_PARITY;
          tx_d       = tx_par_q;
`else
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
`endif
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_d     = tx_shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_end) begin
        tx_state_d = S_STOP;
        tx_bit_d   = '0;
        tx_d       = 1'b1;
      end
`endif
      S_STOP: if (tx_end) begin
        tx_d = 1'b1;
        if (tx_bit_q == LAST_SBIT) tx_state_d = S_IDLE;
        else                       tx_bit_d   = tx_bit_q + 3'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0]             rx_sync_q, rx_sync_d;
  state_e                 rx_state_q, rx_state_d;
  logic [3:0]             rx_cnt_q, rx_cnt_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [1:0]             rx_err_q, rx_err_d;
  logic                   rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic                   rxs, rx_end, perr;
`ifdef UART_PARITY_EN
  logic                   rx_perr_q, rx_perr_d;
  assign perr = rx_perr_q;
`else
  assign perr = 1'b0;
`endif

  assign rxs        = rx_sync_q[1];
  assign rx_end     = tick && (rx_cnt_q == LAST_TICK);
  assign rx_data    = rx_data_q;
  assign rx_err     = rx_err_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_ovr_q;

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (tick) rx_cnt_d = rx_cnt_q + 4'd1;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs) rx_state_d = S_START;
      end
      // Mid start bit: a line already back high was a glitch, not a frame.
      S_START: if (tick && rx_cnt_q == MID_TICK) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_DBIT) begin
`ifdef UART_PARITY_EN
          rx_state_d = S_PARITY;
`else
          rx_state_d = S_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_end) begin
        rx_perr_d  = rxs ^ (^rx_shift_q) ^ 1'(PARITY_ODD);
        rx_state_d = S_STOP;
      end
`endif
      // Only the first stop bit is checked; returning to IDLE here allows back-to-back frames.
      S_STOP: if (rx_end) begin
        rx_state_d = S_IDLE;
        rx_data_d  = rx_shift_q;
        rx_err_d   = {perr, ~rxs};
        rx_valid_d = 1'b1;
        rx_ovr_d   = rx_valid_q && !rx_ready;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_sync_q  <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_err_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at 16 clk per bit (DIV=1); parity cases only with UART_PARITY_EN.
module tb_uart_core;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       tx, tx_ready, tx_done, rx_valid, rx_overrun, rx;
  logic       tx_valid = 1'b0, rx_ready = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic [1:0] rx_err;
  int         errors = 0, checks = 0, ovr_cnt = 0;

  assign rx = loop ? tx : rx_drv;

  uart_core #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_err(rx_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  // Expected serial bit i of a frame carrying d (even parity).
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic send_tx_check(input logic [7:0] d, input string name);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s pre-accept tx_ready: got %b want 1", name, tx_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= NB * 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++; $display("FAIL %s busy tx_ready: got %b want 0", name, tx_ready);
        end
        tx_data = ~d;   // must be ignored while busy
      end
      if (k == 100) tx_valid = 1'b0;
      checks++;
      if (tx !== exp_bit(d, (k - 1) / 16) || tx_done !== (k == NB * 16)) begin
        errors++;
        $display("FAIL %s cyc %0d: tx=%b done=%b want tx=%b done=%b",
                 name, k, tx, tx_done, exp_bit(d, (k - 1) / 16), (k == NB * 16));
      end
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1 || tx_done !== 1'b0) begin
      errors++; $display("FAIL %s post-frame: ready=%b tx=%b done=%b want 1 1 0",
                         name, tx_ready, tx, tx_done);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par, input int stop_low);
    @(negedge clk);
    for (int i = 0; i < NB - 1; i++) begin
      if (i == 0)      rx_drv = 1'b0;
      else if (i <= 8) rx_drv = d[i-1];
      else             rx_drv = par;
      repeat (16) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (16 - stop_low) @(negedge clk);
  endtask

  task automatic check_rx(input logic [7:0] d, input logic [1:0] e, input string name);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== d || rx_err !== e) begin
      errors++; $display("FAIL %s rx: valid=%b data=%h err=%b want 1 %h %b",
                         name, rx_valid, rx_data, rx_err, d, e);
    end
  endtask

  task automatic ack_rx(input string name);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL %s ack rx_valid: got %b want 0", name, rx_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (tx !== 1'b1)         begin errors++; $display("FAIL reset tx: got %b want 1", tx); end
    if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
    if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset tx_done: got %b want 0", tx_done); end
    if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    if (rx_err !== 2'b00)    begin errors++; $display("FAIL reset rx_err: got %b want 00", rx_err); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset rx_overrun: got %b want 0", rx_overrun); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx;
    send_tx_check(8'hA5, "tx_a5");
  endtask

  task automatic test_loopback;
    bit seen = 0;
    loop = 1'b1;
    send_tx_check(8'h3C, "loop_3c");
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rx_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL loop_3c timeout: rx_valid never 1, want 1"); end
    check_rx(8'h3C, 2'b00, "loop_3c");
    loop = 1'b0;
    ack_rx("loop_3c");
  endtask

  task automatic test_false_start;
    @(negedge clk) rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL false_start rx_valid: got %b want 0", rx_valid);
    end
    send_rx(8'h5A, ^8'h5A, 0);
    check_rx(8'h5A, 2'b00, "after_glitch");
    ack_rx("after_glitch");
  endtask

  task automatic test_frame_err;
    send_rx(8'h96, ^8'h96, 11);
    repeat (30) @(negedge clk);
    check_rx(8'h96, 2'b01, "frame_err");
    ack_rx("frame_err");
  endtask

  task automatic test_back_to_back;
    int o0 = ovr_cnt;
    send_rx(8'h11, ^8'h11, 0);
    send_rx(8'h22, ^8'h22, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 != 1) begin
      errors++; $display("FAIL overrun pulses: got %0d want 1", ovr_cnt - o0);
    end
    check_rx(8'h22, 2'b00, "overrun_data");
    ack_rx("overrun");
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    send_rx(8'h01, 1'b0, 0);
    check_rx(8'h01, 2'b10, "parity_bad");
    ack_rx("parity_bad");
    send_rx(8'h01, 1'b1, 0);
    check_rx(8'h01, 2'b00, "parity_good");
    ack_rx("parity_good");
  endtask
`endif

  task automatic test_reset_mid_tx;
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk) tx_valid = 1'b0;
    repeat (68) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      errors++; $display("FAIL mid_tx_reset: tx=%b ready=%b done=%b want 1 1 0",
                         tx, tx_ready, tx_done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_tx_check(8'hC3, "after_reset");
  endtask

  initial begin
    test_reset;
    test_tx;
    test_loopback;
    test_false_start;
    test_frame_err;
    test_back_to_back;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    test_reset_mid_tx;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line bit rate.
REQ-003 Parameter DATA_BITS, 8, payload width; legal range 5..8.
REQ-004 Parameter STOP_BITS, 1, stop bit count; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, 0, parity sense (0 even, 1 odd); used only when UART_PARITY_EN is defined.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 rx  in  1  asynchronous serial input, idle high.
REQ-009 tx  out  1  serial output, idle high.
REQ-010 tx_data  in  DATA_BITS  byte to transmit.
REQ-011 tx_valid  in  1  transmit request.
REQ-012 tx_ready  out  1  transmitter idle, can accept.
REQ-013 tx_done  out  1  one-cycle pulse at frame end.
REQ-014 rx_data  out  DATA_BITS  last received payload.
REQ-015 rx_valid  out  1  rx_data holds unread frame.
REQ-016 rx_ready  in  1  consumer acknowledge.
REQ-017 rx_err  out  2  {parity_err, frame_err} of the frame in rx_data, valid while rx_valid.
REQ-018 rx_overrun  out  1  one-cycle pulse when a frame completes while rx_valid is high.

Function
REQ-019 A baud-16 tick SHALL assert for one clk every DIV = CLK_HZ/(16*BAUD) cycles (integer division); DIV < 1 SHALL be an elaboration error.
REQ-020 One bit period SHALL equal exactly 16 ticks.
REQ-021 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 tx_ready SHALL be high only in IDLE; transfer occurs on clk edge with tx_valid && tx_ready, latching tx_data.
REQ-023 START SHALL begin on the edge after acceptance; frame = start(0), DATA_BITS LSB first, parity bit (if enabled), STOP_BITS ones.
REQ-024 tx_done SHALL pulse in the last cycle of the final stop bit; FSM returns to IDLE and tx_ready rises on the next edge.
REQ-025 tx_valid changes outside IDLE SHALL be ignored; tx_data SHALL be sampled only at acceptance.
REQ-026 rx SHALL pass a two-flop synchronizer before any use.
REQ-027 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-028 In IDLE a synchronized low SHALL enter START; at tick 8 rx high SHALL return to IDLE (false start), else sampling continues.
REQ-029 Each subsequent bit SHALL be sampled once, 16 ticks after the previous sample (mid-bit).
REQ-030 Only the first stop bit SHALL be checked; sampled 0 sets frame_err.
REQ-031 At the first stop-bit sample, rx_data/rx_err SHALL load and rx_valid SHALL set on the same edge; RX returns to IDLE immediately, allowing back-to-back frames.
REQ-032 rx_valid SHALL clear on the edge with rx_valid && rx_ready.
REQ-033 A frame completing while rx_valid is high and rx_ready low SHALL overwrite rx_data/rx_err, keep rx_valid high, and pulse rx_overrun.
REQ-034 Simultaneous completion and rx_ready SHALL leave rx_valid high with the new frame, no overrun.
REQ-035 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-036 rst high SHALL force both FSMs to IDLE and clear the tick counter, mid-frame included.
REQ-037 Reset values: tx=1, tx_ready=1, tx_done=0, rx_valid=0, rx_data=0, rx_err=0, rx_overrun=0, synchronizer flops=1.

Configuration
REQ-038 With UART_PARITY_EN defined, TX SHALL insert parity (XOR of data, inverted if PARITY_ODD) and RX SHALL check it, setting parity_err on mismatch.
REQ-039 Without UART_PARITY_EN, PARITY states SHALL be absent, no parity bit SHALL be sent or expected, and parity_err SHALL be tied 0.

Structure
REQ-040 Package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE=16 and the DIV computation function.
REQ-041 Sub-module uart_baud_gen SHALL produce the baud-16 tick; TX and RX FSMs live in uart_core.

Verification (CLK_HZ=1_600_000, BAUD=100_000 -> DIV=1, 16 clk/bit)
REQ-042 Send tx_data=8'hA5 -> tx line 0,1,0,1,0,0,1,0,1,1 each 16 clk; tx_done pulse at clk 160 after acceptance.
REQ-043 Loop tx to rx, send 8'h3C -> rx_valid with rx_data=8'h3C, rx_err=2'b00.
REQ-044 rx low pulse of 5 clk -> no rx_valid, RX back in IDLE.
REQ-045 Frame with stop bit 0 -> rx_valid, frame_err=1; two frames with rx_ready=0 -> rx_overrun pulse, rx_data=second byte.
REQ-046 UART_PARITY_EN, PARITY_ODD=0, receive 8'h01 with parity 0 -> parity_err=1; with parity 1 -> 0.
REQ-047 rst asserted mid-TX at bit 4 -> next edge tx=1, tx_ready=1; next send correct.
